weight_bit_serializer: RTL and testbench
========================================

# weight_bit_serializer

Feeds the serial MAC datapath with weight bits, one bit per cycle, least significant bit first. It accepts a parallel two's-complement weight word through a valid/ready handshake and shifts it out. On the final (MSB) bit it asserts `w_en` and presents the weight's sign bit on `MSB_w`. The downstream accumulate/negate stage uses that pair to latch the sign-extended partial sum and negate it when the MSB weight bit is 1.

## Interface
- `Pw`, default 8: weight word width in bits; legal range 2..32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous abort of the word in flight.
- `w_valid`  in  1  parallel weight word available.
- `w_data`  in  Pw  two's-complement weight word.
- `w_ready`  out  1  serializer can accept a word this cycle.
- `w_bit`  out  1  current serial weight bit.
- `bit_en`  out  1  `w_bit` valid this cycle.
- `bit_idx`  out  $clog2(Pw)  index of the bit currently on `w_bit`.
- `w_en`  out  1  final-bit strobe; high only while `bit_idx == Pw-1`.
- `MSB_w`  out  1  equals `w_data[Pw-1]` of the current word while `w_en` is high; 0 otherwise.
- `busy`  out  1  a word is being shifted.

## Operation
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - `w_ready=1`.
  - When `w_valid & w_ready`, capture `w_data` into the shift register and clear `bit_idx` to 0.
  - Go to SHIFT.
- SHIFT:
  - Drive `bit_en=1`, `busy=1`, `w_bit=shreg[0]`.
  - Each cycle, shift the register right by 1 and increment `bit_idx`.
- At `bit_idx == Pw-1`:
  - Assert `w_en=1` and `MSB_w=sign`.
  - `sign` is latched from `w_data[Pw-1]` at accept, not taken from the shifted register.
  - Next state is IDLE, or SHIFT with a new word under WSER_PRELOAD_EN (see Configuration).
- `flush` high, any state: next state is IDLE, `bit_idx` is cleared, and no `w_en` is issued for the aborted word.
- `flush` and `w_valid` high in the same cycle: `flush` wins; `w_ready` is forced to 0 that cycle, so no accept occurs.
- `w_data` is sampled only on the accept edge; later changes to `w_data` are ignored.
- All outputs are registered.

## Timing
- Reset values: `w_ready=0` while `rst_n=0`, becoming 1 in IDLE after release; all other outputs are 0; state is IDLE.
- Reset asserted mid-word: the word is discarded, no `w_en` is issued, and outputs go to 0 asynchronously.
- Latency: accept on edge N, so bit 0 is on `w_bit` with `bit_en=1` during cycle N+1.
- Duration: bit k appears in cycle N+1+k; `w_en` is high in cycle N+Pw only.
- Throughput without the macro: one word per Pw+1 cycles, with one idle bubble in which `w_ready=1` and `bit_en=0`.
- `bit_en` is never high in a cycle where `bit_idx` has not been updated for that cycle's bit.
- `w_en` and `MSB_w` are mutually aligned: the downstream stage sees both on the same edge.

## Configuration
- Macro: `WSER_PRELOAD_EN`.
- Defined:
  - `w_ready` is also 1 during the final-bit cycle of SHIFT, unless `flush` is high.
  - An accept in that cycle reloads the shift register and `sign`, and clears `bit_idx`; the state stays SHIFT.
  - Bit 0 of the new word follows the previous MSB with no gap, giving one word per Pw cycles.
  - `w_en`/`MSB_w` still refer to the outgoing word in that cycle.
- Undefined:
  - `w_ready` is 1 only in IDLE.
  - The final-bit cycle always returns to IDLE, giving the one-cycle bubble.

## Test plan
- Basic word, Pw=8, `w_data=8'h5A`, single accept: `w_bit` sequence 0,1,0,1,1,0,1,0 over 8 cycles with `bit_en=1`; `w_en=1` in the 8th cycle only, `MSB_w=0`.
- Negative weight, `w_data=8'hB3`: bits 1,1,0,0,1,1,0,1; on the final bit `w_en=1` and `MSB_w=1`; `bit_idx` reads 7 in that cycle.
- Back-to-back `8'h81` then `8'h7F`, `w_valid` held high:
  - Without the macro: a one-cycle gap with `bit_en=0` between the two words.
  - With `WSER_PRELOAD_EN`: 16 contiguous `bit_en` cycles and `w_en` pulses exactly 8 cycles apart; `MSB_w` reads 1 then 0.
- Flush at `bit_idx=3` of `8'hFF`: next cycle `busy=0`, `bit_en=0`, and no `w_en` appears; a following word `8'h01` serializes normally.
- Collision: `flush=1` and `w_valid=1` in IDLE: `w_ready=0`, the word is not accepted, and the state remains IDLE.
- Reset: `rst_n` pulled low at `bit_idx=5`: all outputs 0 immediately; after release, `w_ready=1` and the next accept starts from bit 0.

Source files
------------

// File: rtl/weight_bit_serializer_if.sv
// Parallel weight-word handshake into the bit serializer.
interface weight_bit_serializer_if #(
  parameter int Pw = 8
);
  logic          w_valid;
  logic [Pw-1:0] w_data;
  logic          w_ready;

  modport master (output w_valid, output w_data, input w_ready);
  modport slave  (input w_valid, input w_data, output w_ready);
endinterface

// File: rtl/weight_bit_serializer.sv
// LSB-first weight bit serializer for the serial MAC; flags the sign bit on the final bit.
// Optional WSER_PRELOAD_EN: accept the next word during the final bit for gapless streaming.
module weight_bit_serializer #(
  parameter  int Pw = 8,
  localparam int IW = (Pw > 1) ? $clog2(Pw) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  weight_bit_serializer_if.slave  w_if,
  output logic                    w_bit,
  output logic                    bit_en,
  output logic [IW-1:0]           bit_idx,
  output logic                    w_en,
  output logic                    MSB_w,
  output logic                    busy
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [IW-1:0] LAST = IW'(Pw - 1);

  state_t        state, nstate;
  logic [Pw-1:0] shreg, nshreg;
  logic [IW-1:0] nidx;
  logic          sign, nsign;
  logic          rdy_q, nrdy;
  logic          accept, last;

  // flush overrides an offered word in the same cycle
  assign w_if.w_ready = rdy_q & ~flush;
  assign accept       = w_if.w_valid & w_if.w_ready;
  assign last         = (state == SHIFT) && (bit_idx == LAST);
  assign w_bit        = shreg[0];

  always_comb begin
    nstate = state;
    nshreg = shreg;
    nidx   = bit_idx;
    nsign  = sign;
    case (state)
      IDLE: begin
        nshreg = '0;
        nidx   = '0;
        if (accept) begin
          nstate = SHIFT;
          nshreg = w_if.w_data;
          nsign  = w_if.w_data[Pw-1];
        end
      end
      SHIFT: begin
        nshreg = shreg >> 1;
        nidx   = bit_idx + IW'(1);
        if (last) begin
`ifdef WSER_PRELOAD_EN
          if (accept) begin
            nshreg = w_if.w_data;
            nsign  = w_if.w_data[Pw-1];
            nidx   = '0;
          end else begin
            nstate = IDLE;
            nidx   = '0;
          end
`else
          nstate = IDLE;
          nidx   = '0;
`endif
        end
      end
      default: nstate = IDLE;
    endcase
    if (flush) begin
      nstate = IDLE;
      nidx   = '0;
      nshreg = '0;
    end
  end

  // ready for the next cycle: idle, or (preload) about to present the final bit
  always_comb begin
    nrdy = (nstate == IDLE);
`ifdef WSER_PRELOAD_EN
    if (nstate == SHIFT && nidx == LAST) nrdy = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      sign    <= 1'b0;
      rdy_q   <= 1'b0;
      bit_en  <= 1'b0;
      busy    <= 1'b0;
      w_en    <= 1'b0;
      MSB_w   <= 1'b0;
    end else begin
      state   <= nstate;
      shreg   <= nshreg;
      bit_idx <= nidx;
      sign    <= nsign;
      rdy_q   <= nrdy;
      bit_en  <= (nstate == SHIFT);
      busy    <= (nstate == SHIFT);
      w_en    <= (nstate == SHIFT) && (nidx == LAST);
      MSB_w   <= (nstate == SHIFT) && (nidx == LAST) && nsign;
    end
  end
endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed bench for weight_bit_serializer (Pw=8), table-driven words plus corner sequences.
module tb_weight_bit_serializer;
  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       w_bit, bit_en, w_en, MSB_w, busy;
  logic [2:0] bit_idx;

  weight_bit_serializer_if #(.Pw(PW)) wif ();

  weight_bit_serializer #(.Pw(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .w_if    (wif),
    .w_bit   (w_bit),
    .bit_en  (bit_en),
    .bit_idx (bit_idx),
    .w_en    (w_en),
    .MSB_w   (MSB_w),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (wif.w_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " ready"}, 32'(wif.w_ready), 32'd1);
  endtask

  // seq[7] is the first bit expected on w_bit
  task automatic send_word(input logic [7:0] d, input logic [7:0] seq, input logic msb,
                           input string tag);
    logic exp_rdy;
    wait_ready(tag);
    wif.w_valid = 1'b1;
    wif.w_data  = d;
    step();
    wif.w_valid = 1'b0;
    wif.w_data  = ~d;
    for (int k = 0; k < 8; k++) begin
`ifdef WSER_PRELOAD_EN
      exp_rdy = (k == 7);
`else
      exp_rdy = 1'b0;
`endif
      chk($sformatf("%s b%0d bit_en", tag, k), 32'(bit_en), 32'd1);
      chk($sformatf("%s b%0d busy", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s b%0d idx", tag, k), 32'(bit_idx), 32'(k));
      chk($sformatf("%s b%0d w_bit", tag, k), 32'(w_bit), 32'(seq[7-k]));
      chk($sformatf("%s b%0d w_en", tag, k), 32'(w_en), 32'(k == 7));
      chk($sformatf("%s b%0d MSB_w", tag, k), 32'(MSB_w), 32'((k == 7) ? msb : 1'b0));
      chk($sformatf("%s b%0d w_ready", tag, k), 32'(wif.w_ready), 32'(exp_rdy));
      step();
    end
    chk({tag, " end bit_en"}, 32'(bit_en), 32'd0);
    chk({tag, " end w_en"}, 32'(w_en), 32'd0);
    chk({tag, " end busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       msb;
  } vec_t;

  vec_t vecs[6];

  logic       rec_be[18], rec_we[18], rec_mb[18], rec_wb[18];
  logic [7:0] seq81, seq7f;
  int         acc, off2;
  logic       in1, in2, e_wb;

  initial begin
    vecs[0] = '{8'h5A, 8'b01011010, 1'b0};
    vecs[1] = '{8'hB3, 8'b11001101, 1'b1};
    vecs[2] = '{8'h01, 8'b10000000, 1'b0};
    vecs[3] = '{8'h80, 8'b00000001, 1'b1};
    vecs[4] = '{8'hFF, 8'b11111111, 1'b1};
    vecs[5] = '{8'h6E, 8'b01110110, 1'b0};

    wif.w_valid = 1'b0;
    wif.w_data  = '0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst w_ready", 32'(wif.w_ready), 32'd0);
    chk("rst bit_en", 32'(bit_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst w_en", 32'(w_en), 32'd0);
    chk("rst MSB_w", 32'(MSB_w), 32'd0);
    chk("rst w_bit", 32'(w_bit), 32'd0);
    chk("rst idx", 32'(bit_idx), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post-rst w_ready", 32'(wif.w_ready), 32'd1);

    foreach (vecs[i]) send_word(vecs[i].data, vecs[i].seq, vecs[i].msb, $sformatf("vec%0d", i));

    // back-to-back 81 then 7F with w_valid held
    wait_ready("b2b");
    wif.w_valid = 1'b1;
    wif.w_data  = 8'h81;
    acc = 0;
    for (int c = 0; c < 18; c++) begin
      if (wif.w_valid && wif.w_ready) acc++;
      step();
      if (acc == 1) wif.w_data = 8'h7F;
      if (acc >= 2) wif.w_valid = 1'b0;
      rec_be[c] = bit_en;
      rec_we[c] = w_en;
      rec_mb[c] = MSB_w;
      rec_wb[c] = w_bit;
    end
    wif.w_valid = 1'b0;
    seq81 = 8'b10000001;
    seq7f = 8'b11111110;
`ifdef WSER_PRELOAD_EN
    off2 = 8;
`else
    off2 = 9;
`endif
    for (int c = 0; c < 18; c++) begin
      in1  = (c < 8);
      in2  = (c >= off2) && (c < off2 + 8);
      e_wb = in1 ? seq81[7-c] : (in2 ? seq7f[7-(c-off2)] : 1'b0);
      chk($sformatf("b2b c%0d bit_en", c), 32'(rec_be[c]), 32'(in1 | in2));
      chk($sformatf("b2b c%0d w_en", c), 32'(rec_we[c]), 32'((c == 7) || (c == off2 + 7)));
      chk($sformatf("b2b c%0d MSB_w", c), 32'(rec_mb[c]), 32'(c == 7));
      chk($sformatf("b2b c%0d w_bit", c), 32'(rec_wb[c]), 32'(e_wb));
    end

    // flush at bit_idx 3 of FF
    wait_ready("flush");
    wif.w_valid = 1'b1;
    wif.w_data  = 8'hFF;
    step();
    wif.w_valid = 1'b0;
    step();
    step();
    step();
    chk("flush idx3", 32'(bit_idx), 32'd3);
    flush = 1'b1;
    chk("flush w_ready", 32'(wif.w_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush bit_en", 32'(bit_en), 32'd0);
    chk("flush idx", 32'(bit_idx), 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("flush c%0d w_en", c), 32'(w_en), 32'd0);
      step();
    end
    send_word(8'h01, 8'b10000000, 1'b0, "postflush");

    // flush and w_valid together in IDLE
    flush       = 1'b1;
    wif.w_valid = 1'b1;
    wif.w_data  = 8'hAA;
    #1;
    chk("coll w_ready", 32'(wif.w_ready), 32'd0);
    step();
    flush       = 1'b0;
    wif.w_valid = 1'b0;
    chk("coll busy", 32'(busy), 32'd0);
    chk("coll bit_en", 32'(bit_en), 32'd0);
    step();
    chk("coll busy2", 32'(busy), 32'd0);
    chk("coll w_ready2", 32'(wif.w_ready), 32'd1);

    // reset mid-word at bit_idx 5
    wait_ready("rstmid");
    wif.w_valid = 1'b1;
    wif.w_data  = 8'hFF;
    step();
    wif.w_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("rstmid idx5", 32'(bit_idx), 32'd5);
    chk("rstmid w_bit pre", 32'(w_bit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid w_bit", 32'(w_bit), 32'd0);
    chk("rstmid bit_en", 32'(bit_en), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid idx", 32'(bit_idx), 32'd0);
    chk("rstmid w_en", 32'(w_en), 32'd0);
    chk("rstmid MSB_w", 32'(MSB_w), 32'd0);
    chk("rstmid w_ready", 32'(wif.w_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid post w_ready", 32'(wif.w_ready), 32'd1);
    chk("rstmid post w_en", 32'(w_en), 32'd0);
    send_word(8'hB3, 8'b11001101, 1'b1, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
